mul_sequencer: RTL

Multi-cycle multiply unit and controller for the MIPS core's HI/LO path. On `multu` (decoder `domul`) it latches both register operands and runs a radix-2 shift-add sequence over WIDTH cycles, then writes the 2×WIDTH product into HI/LO. On `mfhi`/`mflo` (decoder `multoreg`/`lohi`) it returns the selected register. Any multiply or HI/LO access issued while a multiply is in flight raises `stall` until the result is committed.

---
 rtl/mul_sequencer.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/mul_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : mul_sequencer
// Brief    : Multi-cycle radix-2 shift-add multiplier and HI/LO controller
//            for the MIPS multu / mfhi / mflo path. Raises stall while a
//            multiply is in flight and a new multiply or HI/LO read arrives.
//            Optional feature macro: MUL_SIGNED_EN (signed multiply via
//            magnitude multiply plus final two's-complement negation).
// Revision : 1.0 - initial release
// ============================================================================
module mul_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             rd_req,
  input  logic             rd_hi,
  output logic [WIDTH-1:0] result,
  output logic             busy,
  output logic             stall,
  output logic             done
);

  localparam int               CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]         state_q, state_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [2*WIDTH-1:0] acc_q,   acc_d;
  logic [CNT_W-1:0]   cnt_q,   cnt_d;
  logic [WIDTH-1:0]   hi_q,    hi_d;
  logic [WIDTH-1:0]   lo_q,    lo_d;
  logic               done_q,  done_d;

  // Datapath helpers
  logic [WIDTH:0]     sum_w;
  logic [2*WIDTH-1:0] step_w;
  logic [2*WIDTH-1:0] prod_w;
  logic [WIDTH-1:0]   op_a_w;
  logic [WIDTH-1:0]   op_b_w;

`ifdef MUL_SIGNED_EN
  logic neg_q, neg_d;
  logic a_neg_w, b_neg_w;

  // Signed operands are multiplied as magnitudes; the most negative value
  // negates to itself, which read as unsigned is exactly its magnitude.
  always_comb begin
    a_neg_w = is_signed & a[WIDTH-1];
    b_neg_w = is_signed & b[WIDTH-1];
    op_a_w  = a_neg_w ? -a : a;
    op_b_w  = b_neg_w ? -b : b;
    prod_w  = neg_q ? -step_w : step_w;
  end
`else
  logic unused_is_signed;
  assign unused_is_signed = is_signed;

  // Unsigned only: operands and product pass straight through.
  always_comb begin
    op_a_w = a;
    op_b_w = b;
    prod_w = step_w;
  end
`endif

  // One shift-add step: conditional add into the upper half keeping the
  // carry, then shift the {carry, acc} word right by one.
  always_comb begin
    sum_w  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
    step_w = {sum_w, acc_q[WIDTH-1:1]};
  end

  // Sequencer next-state: latch on start in IDLE, step each RUN cycle,
  // commit HI/LO on the final step only.
  always_comb begin
    state_d = state_q;
    mcand_d = mcand_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
`ifdef MUL_SIGNED_EN
    neg_d   = neg_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          mcand_d = op_a_w;
          acc_d   = {{WIDTH{1'b0}}, op_b_w};
          cnt_d   = '0;
`ifdef MUL_SIGNED_EN
          neg_d   = a_neg_w ^ b_neg_w;
`endif
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        acc_d = step_w;
        cnt_d = cnt_q + CNT_ONE;
        if (cnt_q == CNT_LAST) begin
          hi_d    = prod_w[2*WIDTH-1:WIDTH];
          lo_d    = prod_w[WIDTH-1:0];
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers; reset abandons any multiply in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      mcand_q <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
`ifdef MUL_SIGNED_EN
      neg_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      mcand_q <= mcand_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
`ifdef MUL_SIGNED_EN
      neg_q   <= neg_d;
`endif
    end
  end

  // Outputs: stall is purely combinational so the decoder freezes the same cycle.
  always_comb begin
    busy   = (state_q == ST_RUN);
    stall  = busy & (start | rd_req);
    done   = done_q;
    result = rd_hi ? hi_q : lo_q;
  end

endmodule
`default_nettype wire
